// File: rtl/mii_frame_dumper.sv
// MII receive capture into a byte buffer, replayed as ASCII binary or hex
// over a ready/valid character stream, with frame/drop/overflow statistics.
module mii_frame_dumper #(
    parameter int DEPTH          = 2048,
    parameter int STRIP_PREAMBLE = 1,
    parameter int DROP_ERR       = 1,
    parameter int CNT_W          = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     one_shot,
    input  logic                     mode,
    input  logic                     rx_en,
    input  logic                     rx_dv,
    input  logic                     rx_err,
    input  logic [3:0]               rx_data,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [2:0]               state,
    output logic [$clog2(DEPTH):0]   frame_len,
    output logic [CNT_W-1:0]         frames_ok,
    output logic [CNT_W-1:0]         frames_dropped,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HUNT    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_DUMP    = 3'd3;
    localparam logic [2:0] S_TERM    = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             armed_q, armed_d;
    logic             dv_prev_q, dv_prev_d;
    logic             skip_q, skip_d;
    logic [3:0]       prev_nib_q, prev_nib_d;
    logic [3:0]       lo_nib_q, lo_nib_d;
    logic             half_q, half_d;
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic             err_flag_q, err_flag_d;
    logic             overflow_q, overflow_d;
    logic [LW-1:0]    frame_len_q, frame_len_d;
    logic             mode_q, mode_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             pend_q, pend_d;
    logic             byte_vld_q, byte_vld_d;
    logic [7:0]       cur_byte_q, cur_byte_d;
    logic [2:0]       idx_q, idx_d;
    logic             bang_q, bang_d;
    logic [1:0]       term_idx_q, term_idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [CNT_W-1:0] frames_ok_q, frames_ok_d;
    logic [CNT_W-1:0] frames_dropped_q, frames_dropped_d;

    logic [7:0]       buf_mem [DEPTH];
    logic [7:0]       rd_data_q;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [AW-1:0]    mem_ra;
    logic [7:0]       mem_wd;

    logic             drop_inc;
    logic             ok_inc;
    logic             err_now;
    logic             slot_free;
    logic [3:0]       nib;
    logic [7:0]       hex_ch;
    logic [7:0]       bin_ch;
    logic [7:0]       cur_ch;
    logic             last_ch;

    assign err_now   = err_flag_q | rx_err;
    assign slot_free = ~tx_valid_q | tx_ready;
    assign nib       = idx_q[0] ? cur_byte_q[3:0] : cur_byte_q[7:4];
    assign hex_ch    = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
    assign bin_ch    = cur_byte_q[idx_q] ? 8'h31 : 8'h30;
    assign cur_ch    = mode_q ? hex_ch : bin_ch;
    assign last_ch   = mode_q ? idx_q[0] : (idx_q == 3'd7);

    always_comb begin
        state_d          = state_q;
        armed_d          = armed_q;
        dv_prev_d        = dv_prev_q;
        skip_d           = skip_q;
        prev_nib_d       = prev_nib_q;
        lo_nib_d         = lo_nib_q;
        half_d           = half_q;
        wr_ptr_d         = wr_ptr_q;
        err_flag_d       = err_flag_q;
        overflow_d       = overflow_q;
        frame_len_d      = frame_len_q;
        mode_d           = mode_q;
        rd_ptr_d         = rd_ptr_q;
        pend_d           = pend_q;
        byte_vld_d       = byte_vld_q;
        cur_byte_d       = cur_byte_q;
        idx_d            = idx_q;
        bang_d           = bang_q;
        term_idx_d       = term_idx_q;
        tx_data_d        = tx_data_q;
        tx_valid_d       = tx_valid_q;
        frames_ok_d      = frames_ok_q;
        frames_dropped_d = frames_dropped_q;
        mem_we           = 1'b0;
        mem_wa           = wr_ptr_q[AW-1:0];
        mem_wd           = {rx_data, lo_nib_q};
        mem_ra           = rd_ptr_q[AW-1:0];
        drop_inc         = 1'b0;
        ok_inc           = 1'b0;

        if (rx_en) dv_prev_d = rx_dv;
        if (arm) armed_d = 1'b1;

        // Frames that start while we cannot take them are counted when they end
        if (rx_en && rx_dv && !dv_prev_q &&
            ((state_q inside {S_DUMP, S_TERM, S_HALT}) ||
             (state_q == S_IDLE && !armed_q)))
            skip_d = 1'b1;
        if (skip_q && rx_en && !rx_dv) begin
            skip_d   = 1'b0;
            drop_inc = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_en && rx_dv && armed_q && !skip_q) begin
                    if (STRIP_PREAMBLE != 0) begin
                        state_d    = S_HUNT;
                        prev_nib_d = rx_data;
                    end else begin
                        state_d    = S_CAPTURE;
                        wr_ptr_d   = '0;
                        overflow_d = 1'b0;
                        err_flag_d = rx_err;
                        lo_nib_d   = rx_data;
                        half_d     = 1'b1;
                    end
                end
            end
            S_HUNT: begin
                if (rx_en) begin
                    if (!rx_dv) begin
                        state_d  = S_IDLE;
                        drop_inc = 1'b1;
                    end else if (prev_nib_q == 4'h5 && rx_data == 4'hD) begin
                        state_d    = S_CAPTURE;
                        wr_ptr_d   = '0;
                        overflow_d = 1'b0;
                        err_flag_d = 1'b0;
                        half_d     = 1'b0;
                    end else begin
                        prev_nib_d = rx_data;
                    end
                end
            end
            S_CAPTURE: begin
                if (rx_en) begin
                    if (rx_err) err_flag_d = 1'b1;
                    if (rx_dv) begin
                        if (!half_q) begin
                            lo_nib_d = rx_data;
                            half_d   = 1'b1;
                        end else begin
                            half_d = 1'b0;
                            if (!wr_ptr_q[AW]) begin
                                mem_we   = 1'b1;
                                wr_ptr_d = wr_ptr_q + LW'(1);
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    end else if ((err_now && DROP_ERR != 0) ||
                                 wr_ptr_q == '0) begin
                        state_d  = S_IDLE;
                        drop_inc = 1'b1;
                    end else begin
                        state_d     = S_DUMP;
                        mode_d      = mode;
                        frame_len_d = wr_ptr_q;
                        rd_ptr_d    = '0;
                        pend_d      = 1'b0;
                        byte_vld_d  = 1'b0;
                        bang_d      = err_now && DROP_ERR == 0;
                    end
                end
            end
            S_DUMP: begin
                if (!byte_vld_q && !pend_q && rd_ptr_q != frame_len_q) begin
                    pend_d   = 1'b1;
                    rd_ptr_d = rd_ptr_q + LW'(1);
                end
                if (pend_q) begin
                    cur_byte_d = rd_data_q;
                    byte_vld_d = 1'b1;
                    idx_d      = 3'd0;
                    pend_d     = 1'b0;
                end
                if (slot_free) begin
                    if (bang_q) begin
                        tx_data_d  = 8'h21;
                        tx_valid_d = 1'b1;
                        bang_d     = 1'b0;
                    end else if (byte_vld_q) begin
                        tx_data_d  = cur_ch;
                        tx_valid_d = 1'b1;
                        idx_d      = idx_q + 3'd1;
                        if (last_ch) begin
                            byte_vld_d = 1'b0;
                            if (rd_ptr_q == frame_len_q) begin
                                state_d    = S_TERM;
                                term_idx_d = 2'd0;
                            end
                        end
                    end else begin
                        tx_valid_d = 1'b0;
                    end
                end
            end
            S_TERM: begin
                if (slot_free) begin
                    if (term_idx_q == 2'd0) begin
                        tx_data_d  = 8'h0D;
                        tx_valid_d = 1'b1;
                        term_idx_d = 2'd1;
                    end else if (term_idx_q == 2'd1) begin
                        tx_data_d  = 8'h0A;
                        tx_valid_d = 1'b1;
                        term_idx_d = 2'd2;
                    end else begin
                        tx_valid_d = 1'b0;
                        ok_inc     = 1'b1;
                        if (one_shot) begin
                            state_d = S_HALT;
                            armed_d = arm;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_HALT: begin
                if (arm) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (drop_inc && frames_dropped_q != '1)
            frames_dropped_d = frames_dropped_q + CNT_W'(1);
        if (ok_inc && frames_ok_q != '1)
            frames_ok_d = frames_ok_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            armed_q          <= 1'b1;
            dv_prev_q        <= 1'b0;
            skip_q           <= 1'b0;
            prev_nib_q       <= 4'h0;
            lo_nib_q         <= 4'h0;
            half_q           <= 1'b0;
            wr_ptr_q         <= '0;
            err_flag_q       <= 1'b0;
            overflow_q       <= 1'b0;
            frame_len_q      <= '0;
            mode_q           <= 1'b0;
            rd_ptr_q         <= '0;
            pend_q           <= 1'b0;
            byte_vld_q       <= 1'b0;
            cur_byte_q       <= 8'h00;
            idx_q            <= 3'd0;
            bang_q           <= 1'b0;
            term_idx_q       <= 2'd0;
            tx_data_q        <= 8'h00;
            tx_valid_q       <= 1'b0;
            frames_ok_q      <= '0;
            frames_dropped_q <= '0;
        end else begin
            state_q          <= state_d;
            armed_q          <= armed_d;
            dv_prev_q        <= dv_prev_d;
            skip_q           <= skip_d;
            prev_nib_q       <= prev_nib_d;
            lo_nib_q         <= lo_nib_d;
            half_q           <= half_d;
            wr_ptr_q         <= wr_ptr_d;
            err_flag_q       <= err_flag_d;
            overflow_q       <= overflow_d;
            frame_len_q      <= frame_len_d;
            mode_q           <= mode_d;
            rd_ptr_q         <= rd_ptr_d;
            pend_q           <= pend_d;
            byte_vld_q       <= byte_vld_d;
            cur_byte_q       <= cur_byte_d;
            idx_q            <= idx_d;
            bang_q           <= bang_d;
            term_idx_q       <= term_idx_d;
            tx_data_q        <= tx_data_d;
            tx_valid_q       <= tx_valid_d;
            frames_ok_q      <= frames_ok_d;
            frames_dropped_q <= frames_dropped_d;
        end
    end

    // Buffer storage has no reset; its read port is one cycle behind mem_ra
    always_ff @(posedge clk) begin
        if (mem_we) buf_mem[mem_wa] <= mem_wd;
        rd_data_q <= buf_mem[mem_ra];
    end

    assign tx_data        = tx_data_q;
    assign tx_valid       = tx_valid_q;
    assign state          = state_q;
    assign frame_len      = frame_len_q;
    assign frames_ok      = frames_ok_q;
    assign frames_dropped = frames_dropped_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_mii_frame_dumper.sv
// Directed bench: two dumper instances (default build, and a 16-byte buffer
// that keeps errored frames) fed the same MII stream.
module tb_mii_frame_dumper;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HALT = 3'd5;

    logic        clk;
    logic        rst;
    logic        arm;
    logic        one_shot;
    logic        mode;
    logic        rx_en;
    logic        rx_dv;
    logic        rx_err;
    logic [3:0]  rx_data;
    logic        tx_ready = 1'b1;
    int          rdy_mode = 0;

    logic [7:0]  tx_data_a, tx_data_b;
    logic        tx_valid_a, tx_valid_b;
    logic [2:0]  state_a, state_b;
    logic [11:0] frame_len_a;
    logic [4:0]  frame_len_b;
    logic [15:0] ok_a, ok_b, drop_a, drop_b;
    logic        ovf_a, ovf_b;

    int          passes = 0;
    int          total  = 0;
    string       sa = "";
    string       sb = "";
    int          ma, mb;
    logic [7:0]  fb[$];

    mii_frame_dumper #(.DEPTH(2048), .STRIP_PREAMBLE(1), .DROP_ERR(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .arm(arm), .one_shot(one_shot), .mode(mode),
        .rx_en(rx_en), .rx_dv(rx_dv), .rx_err(rx_err), .rx_data(rx_data),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
        .state(state_a), .frame_len(frame_len_a), .frames_ok(ok_a),
        .frames_dropped(drop_a), .overflow(ovf_a)
    );

    mii_frame_dumper #(.DEPTH(16), .STRIP_PREAMBLE(1), .DROP_ERR(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .arm(arm), .one_shot(one_shot), .mode(mode),
        .rx_en(rx_en), .rx_dv(rx_dv), .rx_err(rx_err), .rx_data(rx_data),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
        .state(state_b), .frame_len(frame_len_b), .frames_ok(ok_b),
        .frames_dropped(drop_b), .overflow(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rdy_mode == 0)      tx_ready = 1'b1;
        else if (rdy_mode == 1) tx_ready = 1'($urandom_range(0, 1));
        else                    tx_ready = 1'b0;
    end

    function automatic string ch2s(input logic [7:0] c);
        if (c == 8'h0D) return "<CR>";
        if (c == 8'h0A) return "<LF>";
        return $sformatf("%c", c);
    endfunction

    function automatic string hexs(input logic [3:0] n);
        string t;
        t = "0123456789ABCDEF";
        return t.substr(int'(n), int'(n));
    endfunction

    always @(posedge clk) begin
        if (tx_valid_a && tx_ready) sa <= {sa, ch2s(tx_data_a)};
        if (tx_valid_b && tx_ready) sb <= {sb, ch2s(tx_data_b)};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_s(input string tag, input string obs, input string exp);
        total++;
        assert (obs == exp) passes++;
        else $error("FAIL %s: got \"%s\" expected \"%s\"", tag, obs, exp);
    endtask

    task automatic send_nib(input logic [3:0] d, input logic dv, input logic er);
        @(negedge clk);
        rx_en   = 1'b1;
        rx_dv   = dv;
        rx_err  = er;
        rx_data = d;
        @(negedge clk);
        rx_en   = 1'b0;
        rx_err  = 1'b0;
        rx_data = 4'h0;
    endtask

    task automatic send_frame(input int err_nib, input bit odd);
        for (int i = 0; i < 15; i++) send_nib(4'h5, 1'b1, 1'b0);
        send_nib(4'hD, 1'b1, 1'b0);
        for (int i = 0; i < fb.size(); i++) begin
            send_nib(fb[i][3:0], 1'b1, (2 * i) == err_nib);
            send_nib(fb[i][7:4], 1'b1, (2 * i + 1) == err_nib);
        end
        if (odd) send_nib(4'h7, 1'b1, 1'b0);
        send_nib(4'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!((state_a == S_IDLE || state_a == S_HALT) &&
                 (state_b == S_IDLE || state_b == S_HALT) &&
                 !tx_valid_a && !tx_valid_b) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic mark();
        ma = sa.len();
        mb = sb.len();
    endtask

    initial begin
        string hex1, bin1, ea, eb;
        int n;
        hex1 = "A53C<CR><LF>";
        bin1 = "1010010100111100<CR><LF>";
        rst = 1'b1; arm = 1'b0; one_shot = 1'b0; mode = 1'b1;
        rx_en = 1'b0; rx_dv = 1'b0; rx_err = 1'b0; rx_data = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_state",    32'(state_a),     32'd0);
        chk("rst_valid",    32'(tx_valid_a),  32'd0);
        chk("rst_data",     32'(tx_data_a),   32'd0);
        chk("rst_len",      32'(frame_len_a), 32'd0);
        chk("rst_ok",       32'(ok_a),        32'd0);
        chk("rst_drop",     32'(drop_a),      32'd0);
        chk("rst_ovf",      32'(ovf_b),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Hex dump of A5 3C
        mark();
        fb = '{8'hA5, 8'h3C};
        send_frame(-1, 1'b0);
        wait_done("hex");
        chk_s("hex_a", sa.substr(ma, sa.len() - 1), hex1);
        chk_s("hex_b", sb.substr(mb, sb.len() - 1), hex1);
        chk("hex_len", 32'(frame_len_a), 32'd2);
        chk("hex_ok",  32'(ok_a),        32'd1);

        // Binary dump with random back-pressure
        mode = 1'b0;
        rdy_mode = 1;
        mark();
        send_frame(-1, 1'b0);
        wait_done("bin");
        chk_s("bin_a", sa.substr(ma, sa.len() - 1), bin1);
        chk_s("bin_b", sb.substr(mb, sb.len() - 1), bin1);
        chk("bin_ok",   32'(ok_a),   32'd2);
        chk("bin_drop", 32'(drop_a), 32'd0);
        rdy_mode = 0;
        mode = 1'b1;

        // rx_err mid-frame: dropped by A, prefixed with '!' by B
        mark();
        send_frame(2, 1'b0);
        wait_done("err");
        chk_s("err_a", sa.substr(ma, sa.len() - 1), "");
        chk_s("err_b", sb.substr(mb, sb.len() - 1), {"!", hex1});
        chk("err_drop_a", 32'(drop_a), 32'd1);
        chk("err_drop_b", 32'(drop_b), 32'd0);
        chk("err_ok_a",   32'(ok_a),   32'd2);

        // 20-byte frame overflows the 16-byte buffer of B only
        fb.delete();
        for (int i = 0; i < 20; i++) fb.push_back(8'(i));
        ea = ""; eb = "";
        for (int i = 0; i < 20; i++) begin
            ea = {ea, hexs(fb[i][7:4]), hexs(fb[i][3:0])};
            if (i < 16) eb = {eb, hexs(fb[i][7:4]), hexs(fb[i][3:0])};
        end
        mark();
        send_frame(-1, 1'b0);
        wait_done("ovf");
        chk_s("ovf_a", sa.substr(ma, sa.len() - 1), {ea, "<CR><LF>"});
        chk_s("ovf_b", sb.substr(mb, sb.len() - 1), {eb, "<CR><LF>"});
        chk("ovf_flag_b", 32'(ovf_b),       32'd1);
        chk("ovf_len_b",  32'(frame_len_b), 32'd16);
        chk("ovf_flag_a", 32'(ovf_a),       32'd0);
        chk("ovf_len_a",  32'(frame_len_a), 32'd20);

        // Odd trailing nibble is discarded
        fb = '{8'hA5, 8'h3C};
        mark();
        send_frame(-1, 1'b1);
        wait_done("odd");
        chk_s("odd_a", sa.substr(ma, sa.len() - 1), hex1);
        chk("odd_len_a",  32'(frame_len_a), 32'd2);
        chk("odd_len_b",  32'(frame_len_b), 32'd2);
        chk("odd_ovf_b",  32'(ovf_b),       32'd0);

        // One-shot: second back-to-back frame is dropped
        one_shot = 1'b1;
        mark();
        send_frame(-1, 1'b0);
        fb = '{8'h11, 8'h22};
        send_frame(-1, 1'b0);
        wait_done("os");
        chk_s("os_a", sa.substr(ma, sa.len() - 1), hex1);
        chk_s("os_b", sb.substr(mb, sb.len() - 1), hex1);
        chk("os_state", 32'(state_a), 32'(S_HALT));
        chk("os_drop_a", 32'(drop_a), 32'd2);
        chk("os_drop_b", 32'(drop_b), 32'd1);

        // Arm, then a third frame is dumped
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("arm_state", 32'(state_a), 32'(S_IDLE));
        fb = '{8'h5A};
        mark();
        send_frame(-1, 1'b0);
        wait_done("arm");
        chk_s("arm_a", sa.substr(ma, sa.len() - 1), "5A<CR><LF>");
        chk("arm_ok_a",  32'(ok_a),    32'd6);
        chk("arm_ok_b",  32'(ok_b),    32'd7);
        chk("arm_halt",  32'(state_b), 32'(S_HALT));

        // Reset while a dump is stalled on tx_ready
        one_shot = 1'b0;
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        rdy_mode = 2;
        fb = '{8'hA5, 8'h3C};
        send_frame(-1, 1'b0);
        n = 0;
        while (!tx_valid_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rd_valid_seen", 32'(tx_valid_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rd_valid_a", 32'(tx_valid_a),  32'd0);
        chk("rd_valid_b", 32'(tx_valid_b),  32'd0);
        chk("rd_state",   32'(state_a),     32'(S_IDLE));
        chk("rd_ok",      32'(ok_a),        32'd0);
        chk("rd_drop",    32'(drop_a),      32'd0);
        chk("rd_len",     32'(frame_len_a), 32'd0);
        rdy_mode = 0;
        mark();
        repeat (30) @(negedge clk);
        chk_s("rd_quiet", sa.substr(ma, sa.len() - 1), "");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
